// File: rtl/unison_readout_sequencer.sv
// Readout sequencer for a bank of digital_unison cores: resets them, runs clk_master in
// NSAMP-period frames, accumulates per-channel 2-bit readouts and streams one frame per channel.
module unison_readout_sequencer #(
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned DIV     = 4,
    parameter int unsigned NSAMP   = 16,
    parameter int unsigned RST_CYC = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [NUM_CH-1:0]     ch_en_i,
    input  logic                  ud_en_cfg_i,
    input  logic [2*NUM_CH-1:0]   read_out_I_i,
    input  logic [2*NUM_CH-1:0]   read_out_Q_i,
    output logic                  rstb_o,
    output logic                  ud_en_o,
    output logic [NUM_CH-1:0]     clk_master_o,
    output logic                  frame_valid_o,
    input  logic                  frame_ready_i,
    output logic [2:0]            frame_ch_o,
    output logic [7:0]            frame_I_o,
    output logic [7:0]            frame_Q_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCrst,
        StHigh,
        StLow,
        StEmit
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [15:0]         per_q, per_d;
    logic [2:0]          ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                stop_pend_q, stop_pend_d;
    logic                ud_en_q;
    logic [7:0]          acc_i_q [NUM_CH];
    logic [7:0]          acc_i_d [NUM_CH];
    logic [7:0]          acc_q_q [NUM_CH];
    logic [7:0]          acc_q_d [NUM_CH];

    logic                start_ok;
    logic                crst_last;
    logic                phase_last;
    logic                frame_last;
    logic                xfer;
    logic                has_next;
    logic [2:0]          first_ch;
    logic [2:0]          next_ch;
    logic [8:0]          sum_i;
    logic [8:0]          sum_q;

    assign start_ok   = start_i && (|ch_en_i);
    assign crst_last  = (cyc_q == 16'(RST_CYC - 1));
    assign phase_last = (cyc_q == 16'(DIV - 1));
    assign frame_last = (per_q == 16'(NSAMP - 1));
    assign xfer       = (state_q == StEmit) && frame_ready_i;

    // Lowest enabled channel, and lowest enabled channel above the one on the stream.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                first_ch = 3'(k);
            end
            if (mask_q[k] && (k > int'(ch_q))) begin
                next_ch  = 3'(k);
                has_next = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StCrst;
                end
            end
            StCrst: begin
                if (crst_last) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (phase_last) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_last) begin
                    state_d = frame_last ? StEmit : StHigh;
                end
            end
            StEmit: begin
                if (xfer && !has_next) begin
                    state_d = (stop_pend_q || stop_i) ? StIdle : StHigh;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: phase/period counters, mask, stream index, accumulators.
    always_comb begin
        cyc_d       = cyc_q + 16'd1;
        per_d       = per_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        sum_i       = '0;
        sum_q       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_i_d[k] = acc_i_q[k];
            acc_q_d[k] = acc_q_q[k];
        end

        if (state_d != state_q || state_q == StIdle || state_q == StEmit) begin
            cyc_d = '0;
        end

        stop_pend_d = stop_pend_q || stop_i;
        if (state_q == StIdle || state_d == StIdle) begin
            stop_pend_d = 1'b0;
        end

        if (state_q == StIdle && start_ok) begin
            mask_d = ch_en_i;
            per_d  = '0;
            ch_d   = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_i_d[k] = '0;
                acc_q_d[k] = '0;
            end
        end

        if (state_q == StHigh && phase_last) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (mask_q[k]) begin
                    sum_i      = {1'b0, acc_i_q[k]} + {7'd0, read_out_I_i[2*k +: 2]};
                    sum_q      = {1'b0, acc_q_q[k]} + {7'd0, read_out_Q_i[2*k +: 2]};
                    acc_i_d[k] = sum_i[8] ? 8'hFF : sum_i[7:0];
                    acc_q_d[k] = sum_q[8] ? 8'hFF : sum_q[7:0];
                end
            end
        end

        if (state_q == StLow && phase_last) begin
            per_d = per_q + 16'd1;
            if (frame_last) begin
                ch_d = first_ch;
            end
        end

        if (xfer) begin
            if (has_next) begin
                ch_d = next_ch;
            end else begin
                per_d = '0;
                ch_d  = '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    acc_i_d[k] = '0;
                    acc_q_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q       <= '0;
            per_q       <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            stop_pend_q <= 1'b0;
            ud_en_q     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_i_q[k] <= '0;
                acc_q_q[k] <= '0;
            end
        end else begin
            cyc_q       <= cyc_d;
            per_q       <= per_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            stop_pend_q <= stop_pend_d;
            ud_en_q     <= ud_en_cfg_i;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_i_q[k] <= acc_i_d[k];
                acc_q_q[k] <= acc_q_d[k];
            end
        end
    end

    // Output logic: everything decodes from registered state, so a reset edge zeroes it all.
    always_comb begin
        busy_o        = (state_q != StIdle);
        rstb_o        = !(state_q == StIdle || state_q == StCrst);
        ud_en_o       = ud_en_q;
        clk_master_o  = '0;
        frame_valid_o = 1'b0;
        frame_ch_o    = '0;
        frame_I_o     = '0;
        frame_Q_o     = '0;
        if (state_q == StHigh) begin
            clk_master_o = mask_q;
        end
        if (state_q == StEmit) begin
            frame_valid_o = 1'b1;
            frame_ch_o    = ch_q;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_q == 3'(k)) begin
                    frame_I_o = acc_i_q[k];
                    frame_Q_o = acc_q_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_unison_readout_sequencer.sv
// Directed bench for unison_readout_sequencer: a vector table for the default-parameter run,
// hand sequences for mask/backpressure/reset, and a second instance for saturation.
module tb_unison_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, ready = 1'b0, ud_cfg = 1'b0;
    logic [5:0]  ch_en = '0;
    logic [11:0] ri = '0, rq = '0;
    logic        rstb, ud_en, valid, busy;
    logic [5:0]  cm;
    logic [2:0]  fch;
    logic [7:0]  fi, fq;

    logic        start_s = 1'b0, ready_s = 1'b0;
    logic [11:0] ri_s = '0, rq_s = '0;
    logic        rstb_s, ud_en_s, valid_s, busy_s;
    logic [5:0]  cm_s;
    logic [2:0]  fch_s;
    logic [7:0]  fi_s, fq_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    unison_readout_sequencer u_dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .stop_i       (stop),
        .ch_en_i      (ch_en),
        .ud_en_cfg_i  (ud_cfg),
        .read_out_I_i (ri),
        .read_out_Q_i (rq),
        .rstb_o       (rstb),
        .ud_en_o      (ud_en),
        .clk_master_o (cm),
        .frame_valid_o(valid),
        .frame_ready_i(ready),
        .frame_ch_o   (fch),
        .frame_I_o    (fi),
        .frame_Q_o    (fq),
        .busy_o       (busy)
    );

    unison_readout_sequencer #(
        .NUM_CH (6),
        .DIV    (1),
        .NSAMP  (128),
        .RST_CYC(2)
    ) u_sat (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start_s),
        .stop_i       (stop),
        .ch_en_i      (ch_en),
        .ud_en_cfg_i  (ud_cfg),
        .read_out_I_i (ri_s),
        .read_out_Q_i (rq_s),
        .rstb_o       (rstb_s),
        .ud_en_o      (ud_en_s),
        .clk_master_o (cm_s),
        .frame_valid_o(valid_s),
        .frame_ready_i(ready_s),
        .frame_ch_o   (fch_s),
        .frame_I_o    (fi_s),
        .frame_Q_o    (fq_s),
        .busy_o       (busy_s)
    );

    typedef struct {
        int         at;
        logic       st;
        logic       rdy;
        logic       stp;
        logic       rstb;
        logic [5:0] cm;
        logic       vld;
        logic [2:0] ch;
        logic [7:0] fi;
        logic [7:0] fq;
        logic       busy;
    } vec_t;

    vec_t va[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk_all(input string tag, input logic e_rstb, input logic [5:0] e_cm,
                           input logic e_vld, input logic [2:0] e_ch, input logic [7:0] e_fi,
                           input logic [7:0] e_fq, input logic e_busy);
        chk({tag, ".rstb"}, 32'(rstb), 32'(e_rstb));
        chk({tag, ".clk_master"}, 32'(cm), 32'(e_cm));
        chk({tag, ".valid"}, 32'(valid), 32'(e_vld));
        chk({tag, ".ch"}, 32'(fch), 32'(e_ch));
        chk({tag, ".I"}, 32'(fi), 32'(e_fi));
        chk({tag, ".Q"}, 32'(fq), 32'(e_fq));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Default run: ch0 I=3 Q=1 per period -> 48/16; stop pulsed in 5th HIGH of 2nd frame.
        //                 at  st rdy stp rstb  cm    vld ch  I   Q  busy
        va.push_back(vec_t'{  1, 1, 0, 0, 0, 6'h00, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{  8, 0, 0, 0, 0, 6'h00, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{  9, 0, 0, 0, 1, 6'h3F, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{ 12, 0, 0, 0, 1, 6'h3F, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{ 13, 0, 0, 0, 1, 6'h00, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{136, 0, 0, 0, 1, 6'h00, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{137, 0, 0, 0, 1, 6'h00, 1, 0, 48, 16, 1});
        va.push_back(vec_t'{141, 0, 0, 0, 1, 6'h00, 1, 0, 48, 16, 1});
        va.push_back(vec_t'{146, 0, 0, 0, 1, 6'h00, 1, 0, 48, 16, 1});
        va.push_back(vec_t'{147, 0, 1, 0, 1, 6'h00, 1, 1,  0,  0, 1});
        va.push_back(vec_t'{151, 0, 1, 0, 1, 6'h00, 1, 5,  0,  0, 1});
        va.push_back(vec_t'{152, 0, 1, 0, 1, 6'h3F, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{185, 0, 1, 0, 1, 6'h3F, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{186, 0, 1, 1, 1, 6'h3F, 0, 0,  0,  0, 1});
        va.push_back(vec_t'{280, 0, 1, 0, 1, 6'h00, 1, 0, 48, 16, 1});
        va.push_back(vec_t'{285, 0, 1, 0, 1, 6'h00, 1, 5,  0,  0, 1});
        va.push_back(vec_t'{286, 0, 1, 0, 0, 6'h00, 0, 0,  0,  0, 0});
        va.push_back(vec_t'{290, 0, 1, 0, 0, 6'h00, 0, 0,  0,  0, 0});

        // Reset: everything low, ud_en held at 0 even with cfg high.
        rst    = 1'b1;
        ud_cfg = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 6'h00, 0, 0, 0, 0, 0);
        chk("reset.ud_en", 32'(ud_en), 32'd0);
        chk("reset.sat_busy", 32'(busy_s), 32'd0);
        rst = 1'b0;
        tick();
        chk("ud_en.delay_hi", 32'(ud_en), 32'd1);
        ud_cfg = 1'b0;
        tick();
        chk("ud_en.delay_lo", 32'(ud_en), 32'd0);

        // Start with an empty mask is ignored.
        start = 1'b1;
        ch_en = 6'h00;
        tick();
        tick();
        chk("empty_mask.busy", 32'(busy), 32'd0);
        chk("empty_mask.rstb", 32'(rstb), 32'd0);
        start = 1'b0;

        ch_en = 6'h3F;
        ri    = 12'h003;
        rq    = 12'h001;
        cyc   = 0;
        foreach (va[i]) begin
            start = va[i].st;
            ready = va[i].rdy;
            stop  = va[i].stp;
            run_to(va[i].at);
            chk_all($sformatf("vec%0d", i), va[i].rstb, va[i].cm, va[i].vld, va[i].ch,
                    va[i].fi, va[i].fq, va[i].busy);
        end
        start = 1'b0;
        stop  = 1'b0;
        ready = 1'b0;

        // Sparse mask 000101, backpressure, then reset mid-EMIT.
        ch_en = 6'b000101;
        ri    = 12'h02D;
        rq    = 12'h03C;
        cyc   = 0;
        start = 1'b1;
        run_to(1);
        start = 1'b0;
        run_to(9);
        chk("mask.high", 32'(cm), 32'h05);
        run_to(13);
        chk("mask.low", 32'(cm), 32'h00);
        run_to(137);
        chk_all("mask.ch0", 1, 6'h00, 1, 0, 16, 0, 1);
        run_to(140);
        chk_all("mask.ch0_hold", 1, 6'h00, 1, 0, 16, 0, 1);
        ready = 1'b1;
        run_to(141);
        chk_all("mask.ch2", 1, 6'h00, 1, 2, 32, 48, 1);
        ready = 1'b0;
        run_to(142);
        chk_all("mask.ch2_hold", 1, 6'h00, 1, 2, 32, 48, 1);
        rst    = 1'b1;
        ud_cfg = 1'b1;
        run_to(143);
        chk_all("emit_reset", 0, 6'h00, 0, 0, 0, 0, 0);
        chk("emit_reset.ud_en", 32'(ud_en), 32'd0);
        rst    = 1'b0;
        ud_cfg = 1'b0;
        tick();

        // Fresh run after reset must start from cleared accumulators.
        ch_en = 6'h3F;
        ri    = 12'h003;
        rq    = 12'h001;
        cyc   = 0;
        start = 1'b1;
        run_to(1);
        start = 1'b0;
        chk_all("restart.crst", 0, 6'h00, 0, 0, 0, 0, 1);
        run_to(9);
        chk_all("restart.high", 1, 6'h3F, 0, 0, 0, 0, 1);
        ready = 1'b1;
        run_to(137);
        chk_all("restart.ch0", 1, 6'h00, 1, 0, 48, 16, 1);
        run_to(138);
        chk_all("restart.ch1", 1, 6'h00, 1, 1, 0, 0, 1);
        run_to(143);
        chk_all("restart.next_frame", 1, 6'h3F, 0, 0, 0, 0, 1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        ready = 1'b0;
        tick();

        // Saturation: NSAMP=128, DIV=1, I=3 per period -> 384 clamps to 255; Q=1 -> 128.
        ri_s    = 12'hFFF;
        rq_s    = 12'h555;
        cyc     = 0;
        start_s = 1'b1;
        run_to(1);
        start_s = 1'b0;
        ready_s = 1'b1;
        run_to(2);
        chk("sat.crst_rstb", 32'(rstb_s), 32'd0);
        run_to(3);
        chk("sat.high", 32'(cm_s), 32'h3F);
        run_to(259);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sat.valid%0d", k), 32'(valid_s), 32'd1);
            chk($sformatf("sat.ch%0d", k), 32'(fch_s), 32'(k));
            chk($sformatf("sat.I%0d", k), 32'(fi_s), 32'd255);
            chk($sformatf("sat.Q%0d", k), 32'(fq_s), 32'd128);
            tick();
        end
        chk("sat.after_valid", 32'(valid_s), 32'd0);
        chk("sat.after_high", 32'(cm_s), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unison_readout_sequencer.md
UNISON_READOUT_SEQUENCER -- requirements
Module: unison_readout_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 6, giving the number of digital_unison channels sequenced.
REQ-002 The block SHALL have parameter DIV, default 4, giving the clk_master half-period in wb_clk_i cycles (DIV >= 1).
REQ-003 The block SHALL have parameter NSAMP, default 16, giving the clk_master periods per frame (NSAMP >= 1).
REQ-004 The block SHALL have parameter RST_CYC, default 8, giving the wb_clk_i cycles rstb_o is held low after start.
REQ-005 The block SHALL have a single clock, wb_clk_i (input, 1 bit); all state updates on its rising edge.
REQ-006 wb_rst_i (input, 1 bit) SHALL be the reset; it is synchronous and active-high.
REQ-007 start_i (input, 1 bit) SHALL request a run; it is a level sampled in IDLE only.
REQ-008 stop_i (input, 1 bit) SHALL request termination after the current frame.
REQ-009 ch_en_i (input, NUM_CH bits) SHALL be the channel enable mask, sampled on leaving IDLE.
REQ-010 ud_en_cfg_i (input, 1 bit) SHALL be the up/down enable, passed to ud_en_o through a register.
REQ-011 read_out_I_i and read_out_Q_i (input, 2*NUM_CH bits each) SHALL carry bits [2k+1:2k] from channel k.
REQ-012 rstb_o, ud_en_o (output, 1 bit each) and clk_master_o (output, NUM_CH bits) SHALL drive the cores.
REQ-013 frame_valid_o (output, 1), frame_ready_i (input, 1), frame_ch_o (output, 3), frame_I_o (output, 8) and frame_Q_o (output, 8) SHALL form the frame stream.
REQ-014 busy_o (output, 1 bit) SHALL be high in every state except IDLE.

Function
REQ-015 The FSM states SHALL be IDLE, CRST, HIGH, LOW and EMIT.
REQ-016 IDLE: rstb_o=0 and clk_master_o=0; on start_i=1 with ch_en_i!=0, latch the mask, clear accumulators and stop_pend, then go to CRST.
REQ-017 start_i SHALL be ignored with ch_en_i==0 and outside IDLE.
REQ-018 CRST: rstb_o=0 for exactly RST_CYC cycles; rstb_o=1 from the first HIGH cycle until return to IDLE.
REQ-019 HIGH: clk_master_o=latched mask for exactly DIV cycles, then LOW.
REQ-020 LOW: clk_master_o=0 for exactly DIV cycles; the period counter increments; at count NSAMP go to EMIT, otherwise go to HIGH.
REQ-021 Sampling: on the last HIGH cycle, each enabled channel k SHALL add unsigned read_out_I_i[2k+1:2k] to accI[k] and read_out_Q_i[2k+1:2k] to accQ[k].
REQ-022 Accumulators SHALL be 8-bit and saturate at 255; disabled channels stay 0.
REQ-023 EMIT: clk_master_o=0; present enabled channels in ascending index, one frame each, frame_ch_o=k, frame_I_o=accI[k], frame_Q_o=accQ[k].
REQ-024 Handshake: a transfer occurs when frame_valid_o&frame_ready_i; while valid and not ready, all frame outputs hold stable and clk_master_o stays 0.
REQ-025 After the last enabled channel transfers, accumulators and the period counter SHALL clear; go to IDLE if stop_pend, else to HIGH.
REQ-026 frame_valid_o SHALL assert in the first EMIT cycle; back-to-back transfers SHALL occur at one frame per cycle when ready is held high.
REQ-027 stop_i=1 in CRST/HIGH/LOW/EMIT SHALL set stop_pend; stop_pend SHALL be cleared only on entry to IDLE; stop_i in IDLE has no effect.
REQ-028 ud_en_o SHALL equal ud_en_cfg_i delayed by one cycle in all states.

Reset
REQ-029 wb_rst_i=1 SHALL force on the next edge, from any state including mid-EMIT: IDLE, rstb_o=0, ud_en_o=0, clk_master_o=0, frame_valid_o=0, frame_ch_o/I/Q=0, busy_o=0, accumulators, counters and stop_pend cleared.

Verification
REQ-030 Defaults, ch_en_i=6'h3F, ch0 I=2'b11, ch0 Q=2'b01, others 0, start pulse -> rstb_o low 8 cycles, 16 clk_master periods of 8 cycles, ch0 frame I=48, Q=16, ch1-5 frames 0/0.
REQ-031 frame_ready_i low 10 cycles at the first EMIT cycle -> frame_valid_o high, ch0 data stable for 10 cycles, clk_master_o=0, then 6 frames in 6 cycles.
REQ-032 ch_en_i=6'b000101 -> only clk_master_o[0] and [2] toggle; exactly two frames, frame_ch_o=0 then 2.
REQ-033 stop_i pulsed in the 5th HIGH phase -> the frame completes, all frames are emitted, then IDLE with rstb_o=0 and busy_o=0.
REQ-034 wb_rst_i asserted during EMIT with valid high and ready low -> the next cycle all outputs are 0 and the state is IDLE; a new start runs normally.
REQ-035 NSAMP=128, all I inputs=2'b11 -> every frame_I_o=255 (saturated, no wrap).
